mc_obct_array: RTL and testbench
================================

MC_OBCT_ARRAY -- requirements
Module: mc_obct_array

Interface
REQ-001 SHALL have parameter CS_NUM, default 8, meaning number of chip selects tracked (1..8).
REQ-002 SHALL have parameter BANK_W, default 2, meaning bank address width (2**BANK_W banks per chip select).
REQ-003 SHALL have parameter ROW_W, default 13, meaning row address width.
REQ-004 SHALL have parameter IDLE_W, default 8, meaning idle-timer and idle_limit width.
REQ-005 SHALL have one clock and an asynchronous, active-low reset.
REQ-006 Ports SHALL be:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- cs  in  CS_NUM  chip-select vector
- row_adr  in  ROW_W  row address
- bank_adr  in  BANK_W  bank address
- bank_set  in  1  activate: open bank_adr with row_adr
- bank_clr  in  1  precharge bank_adr
- bank_clr_all  in  1  precharge all banks of the selected chip selects
- rfr_ack  in  1  refresh: close every bank of every chip select
- bank_touch  in  1  access to bank_adr; restarts its idle timer
- idle_limit  in  IDLE_W  idle close threshold in cycles; 0 disables timeout
- bank_open  out  1  addressed bank is open (registered)
- row_same  out  1  addressed bank is open with a matching row (registered)
- any_bank_open  out  1  any bank of the selected chip select is open (registered)
- close_req  out  1  idle-close request valid
- close_cs  out  3  chip-select index of the request
- close_bank  out  BANK_W  bank of the request
- close_ack  in  1  controller accepted the request and issued the precharge

Function
REQ-007 Each (cs i, bank b) entry SHALL hold: open bit, ROW_W row register, IDLE_W idle counter.
REQ-008 Commands SHALL apply to every i with cs[i]=1.
REQ-009 bank_set SHALL set open, load row_adr, and clear the counter of entry (i, bank_adr).
REQ-010 bank_clr SHALL clear open of entry (i, bank_adr).
REQ-011 bank_clr_all SHALL clear open of all banks of chip select i.
REQ-012 rfr_ack SHALL clear open of all entries regardless of cs.
REQ-013 Same-cycle priority SHALL be: rfr_ack > bank_clr_all > bank_clr > bank_set.
REQ-014 bank_open, row_same and any_bank_open SHALL update one cycle after cs/bank_adr/row_adr are sampled, from pre-update entry state.
- bank_open = OR over i of cs[i] & open[i][bank_adr].
- row_same = OR over i of cs[i] & open[i][bank_adr] & (row[i][bank_adr]==row_adr).
- any_bank_open = OR over i of cs[i] & (OR over b of open[i][b]).
REQ-015 An open entry's counter SHALL increment each cycle and saturate at idle_limit. It SHALL clear on bank_set or bank_touch to that entry. Closed entries SHALL hold counter 0.
REQ-016 An entry SHALL be expired when open, idle_limit!=0 and counter==idle_limit.
REQ-017 The arbiter SHALL select among expired entries round-robin over flat index i*2**BANK_W+b. The search SHALL start after the last granted index; the start index after reset is 0.
REQ-018 close_req/close_cs/close_bank SHALL be registered and SHALL stay stable while close_req=1 and close_ack=0.
REQ-019 On close_req & close_ack, the targeted entry SHALL close. close_req SHALL deassert for at least one cycle before the next grant.
REQ-020 If the pending target closes by bank_clr/bank_clr_all/rfr_ack or is re-touched before ack, close_req SHALL drop the next cycle (withdrawal). A close_ack in that cycle SHALL be ignored.
REQ-021 close_ack with close_req=0 SHALL be ignored.
REQ-022 Unused chip-select slots (index >= CS_NUM) SHALL not exist. close_cs SHALL be zero-extended.

Reset
REQ-023 On rst=0, all open bits, counters, row registers, bank_open, row_same, any_bank_open, close_req, close_cs, close_bank and the round-robin pointer SHALL go to 0 immediately. A pending request SHALL be lost without ack.
REQ-024 After rst deasserts, the first command SHALL be accepted on the first rising edge.

Verification
REQ-025 cs=8'h04, bank_adr=1, row_adr=13'h0123, bank_set; next cycle same address, no command -> one cycle later bank_open=1, row_same=1, any_bank_open=1. With row_adr=13'h0124 -> row_same=0.
REQ-026 Open (cs2,bank1) and (cs5,bank3); pulse rfr_ack together with bank_set to (cs0,bank0) -> all entries closed; any_bank_open=0 for every cs.
REQ-027 idle_limit=4, open (cs1,bank2), no touch -> close_req=1, close_cs=1, close_bank=2 within 5-6 cycles. Hold close_ack=0 for 3 cycles -> outputs stable. Then close_ack -> entry closed, close_req=0.
REQ-028 Expire (cs0,b0), (cs0,b3) and (cs3,b1) simultaneously -> grants in index order 0, 3, 13; re-expire all -> next grant continues round-robin from after 13.
REQ-029 Pending request for (cs1,b2), then bank_clr to it -> close_req=0 next cycle. A late close_ack changes nothing.
REQ-030 idle_limit=0 for 300 cycles with banks open -> close_req never asserts. Assert rst mid-request -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mc_obct_array.sv
// Open-bank / open-row tracker for a multi-chip-select memory controller, with
// per-bank idle timers and a round-robin arbiter that requests idle precharges.
module mc_obct_array #(
  parameter int CS_NUM = 8,
  parameter int BANK_W = 2,
  parameter int ROW_W  = 13,
  parameter int IDLE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CS_NUM-1:0] cs,
  input  logic [ROW_W-1:0]  row_adr,
  input  logic [BANK_W-1:0] bank_adr,
  input  logic              bank_set,
  input  logic              bank_clr,
  input  logic              bank_clr_all,
  input  logic              rfr_ack,
  input  logic              bank_touch,
  input  logic [IDLE_W-1:0] idle_limit,
  output logic              bank_open,
  output logic              row_same,
  output logic              any_bank_open,
  output logic              close_req,
  output logic [2:0]        close_cs,
  output logic [BANK_W-1:0] close_bank,
  input  logic              close_ack
);

  localparam int NB    = 1 << BANK_W;
  localparam int NE    = CS_NUM * NB;
  localparam int IDX_W = (NE > 1) ? $clog2(NE) : 1;

  logic              open_q [CS_NUM][NB];
  logic [ROW_W-1:0]  row_q  [CS_NUM][NB];
  logic [IDLE_W-1:0] cnt_q  [CS_NUM][NB];
  logic              open_n [CS_NUM][NB];
  logic [ROW_W-1:0]  row_n  [CS_NUM][NB];
  logic [IDLE_W-1:0] cnt_n  [CS_NUM][NB];

  logic clr_hit   [CS_NUM][NB];
  logic set_hit   [CS_NUM][NB];
  logic touch_hit [CS_NUM][NB];
  logic pend_hit  [CS_NUM][NB];
  logic withdraw, ack_close;

  logic [NE-1:0]     eligible;
  logic              bank_open_n, row_same_n, any_open_n;
  logic              found;
  logic [IDX_W-1:0]  g_idx;
  logic [IDX_W-1:0]  start_q;
  int                srch_j;

  logic              close_req_q;
  logic [2:0]        close_cs_q;
  logic [BANK_W-1:0] close_bank_q;

  // Command decode per entry; a pending target that is closed or touched withdraws the request
  always_comb begin
    withdraw = 1'b0;
    for (int i = 0; i < CS_NUM; i++) begin
      for (int b = 0; b < NB; b++) begin
        clr_hit[i][b]   = rfr_ack | (cs[i] & (bank_clr_all | (bank_clr & (bank_adr == BANK_W'(b)))));
        set_hit[i][b]   = cs[i] & bank_set & (bank_adr == BANK_W'(b));
        touch_hit[i][b] = cs[i] & bank_touch & (bank_adr == BANK_W'(b));
        pend_hit[i][b]  = close_req_q & (close_cs_q == 3'(i)) & (close_bank_q == BANK_W'(b));
        if (pend_hit[i][b] & (clr_hit[i][b] | set_hit[i][b] | touch_hit[i][b]))
          withdraw = 1'b1;
      end
    end
    ack_close = close_req_q & close_ack & ~withdraw;
  end

  // Entry next state, expiry and status lookup (status reads pre-update state)
  always_comb begin
    eligible    = '0;
    bank_open_n = 1'b0;
    row_same_n  = 1'b0;
    any_open_n  = 1'b0;
    for (int i = 0; i < CS_NUM; i++) begin
      bank_open_n = bank_open_n | (cs[i] & open_q[i][bank_adr]);
      row_same_n  = row_same_n  | (cs[i] & open_q[i][bank_adr] & (row_q[i][bank_adr] == row_adr));
      for (int b = 0; b < NB; b++) begin
        open_n[i][b] = open_q[i][b];
        row_n[i][b]  = row_q[i][b];
        cnt_n[i][b]  = cnt_q[i][b];
        any_open_n   = any_open_n | (cs[i] & open_q[i][b]);
        eligible[i*NB+b] = open_q[i][b] & (idle_limit != '0) & (cnt_q[i][b] == idle_limit)
                         & ~(clr_hit[i][b] | set_hit[i][b] | touch_hit[i][b]);
        if (clr_hit[i][b] | (ack_close & pend_hit[i][b])) begin
          open_n[i][b] = 1'b0;
          cnt_n[i][b]  = '0;
        end else if (set_hit[i][b]) begin
          open_n[i][b] = 1'b1;
          row_n[i][b]  = row_adr;
          cnt_n[i][b]  = '0;
        end else if (!open_q[i][b] || touch_hit[i][b]) begin
          cnt_n[i][b]  = '0;
        end else if (cnt_q[i][b] >= idle_limit) begin
          cnt_n[i][b]  = idle_limit;
        end else begin
          cnt_n[i][b]  = cnt_q[i][b] + 1'b1;
        end
      end
    end
  end

  // Round-robin search starting at start_q
  always_comb begin
    found  = 1'b0;
    g_idx  = '0;
    srch_j = 0;
    for (int k = 0; k < NE; k++) begin
      srch_j = int'(start_q) + k;
      if (srch_j >= NE) srch_j = srch_j - NE;
      if (!found && eligible[srch_j]) begin
        found = 1'b1;
        g_idx = IDX_W'(srch_j);
      end
    end
  end

  // Stage boundary: entry state, status outputs and close request registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CS_NUM; i++) begin
        for (int b = 0; b < NB; b++) begin
          open_q[i][b] <= 1'b0;
          row_q[i][b]  <= '0;
          cnt_q[i][b]  <= '0;
        end
      end
      bank_open     <= 1'b0;
      row_same      <= 1'b0;
      any_bank_open <= 1'b0;
      close_req_q   <= 1'b0;
      close_cs_q    <= '0;
      close_bank_q  <= '0;
      start_q       <= '0;
    end else begin
      open_q        <= open_n;
      row_q         <= row_n;
      cnt_q         <= cnt_n;
      bank_open     <= bank_open_n;
      row_same      <= row_same_n;
      any_bank_open <= any_open_n;
      if (close_req_q) begin
        if (withdraw || close_ack) close_req_q <= 1'b0;
      end else if (found) begin
        close_req_q  <= 1'b1;
        close_cs_q   <= 3'(g_idx >> BANK_W);
        close_bank_q <= BANK_W'(g_idx);
        start_q      <= (g_idx == IDX_W'(NE - 1)) ? '0 : g_idx + 1'b1;
      end
    end
  end

  assign close_req  = close_req_q;
  assign close_cs   = close_cs_q;
  assign close_bank = close_bank_q;

endmodule

// File: tb/tb_mc_obct_array.sv
// Directed self-checking bench for mc_obct_array with hand-computed expectations.
module tb_mc_obct_array;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cs;
  logic [12:0] row_adr;
  logic [1:0]  bank_adr;
  logic        bank_set, bank_clr, bank_clr_all, rfr_ack, bank_touch;
  logic [7:0]  idle_limit;
  logic        bank_open, row_same, any_bank_open;
  logic        close_req;
  logic [2:0]  close_cs;
  logic [1:0]  close_bank;
  logic        close_ack;

  int n_tests = 0;
  int n_fail  = 0;

  mc_obct_array #(.CS_NUM(8), .BANK_W(2), .ROW_W(13), .IDLE_W(8)) dut (
    .clk(clk), .rst(rst), .cs(cs), .row_adr(row_adr), .bank_adr(bank_adr),
    .bank_set(bank_set), .bank_clr(bank_clr), .bank_clr_all(bank_clr_all),
    .rfr_ack(rfr_ack), .bank_touch(bank_touch), .idle_limit(idle_limit),
    .bank_open(bank_open), .row_same(row_same), .any_bank_open(any_bank_open),
    .close_req(close_req), .close_cs(close_cs), .close_bank(close_bank),
    .close_ack(close_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cmds();
    bank_set = 0; bank_clr = 0; bank_clr_all = 0; rfr_ack = 0;
    bank_touch = 0; close_ack = 0;
  endtask

  task automatic do_reset();
    clr_cmds();
    rst = 0;
    tick();
    rst = 1;
  endtask

  task automatic open_bank(input logic [7:0] c, input logic [1:0] b, input logic [12:0] r);
    cs = c; bank_adr = b; row_adr = r; bank_set = 1;
    tick();
    bank_set = 0;
  endtask

  task automatic wait_req(input string tag, output int n);
    n = 0;
    while (close_req !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check(tag, close_req, 1);
  endtask

  task automatic ack_req();
    close_ack = 1;
    tick();
    close_ack = 0;
  endtask

  int n, hits;

  initial begin
    rst = 0; cs = 0; row_adr = 0; bank_adr = 0; idle_limit = 0;
    clr_cmds();
    #2;
    check("rst_bank_open", bank_open, 0);
    check("rst_close_req", close_req, 0);
    check("rst_any_open", any_bank_open, 0);
    tick();
    rst = 1;

    // Open/row-hit lookup
    open_bank(8'h04, 2'd1, 13'h0123);
    check("lookup_preupdate", bank_open, 0);
    tick();
    check("lookup_bank_open", bank_open, 1);
    check("lookup_row_same", row_same, 1);
    check("lookup_any_open", any_bank_open, 1);
    row_adr = 13'h0124;
    tick();
    check("lookup_row_miss", row_same, 0);
    check("lookup_row_miss_open", bank_open, 1);
    cs = 8'h08; bank_adr = 2'd1;
    tick();
    check("other_cs_open", bank_open, 0);
    check("other_cs_any", any_bank_open, 0);
    cs = 8'h04; bank_adr = 2'd2;
    tick();
    check("other_bank_open", bank_open, 0);
    check("other_bank_any", any_bank_open, 1);

    // Refresh wins over a simultaneous activate
    open_bank(8'h20, 2'd3, 13'h0055);
    cs = 8'h24;
    tick();
    check("two_open_bank", bank_open, 1);
    cs = 8'h01; bank_adr = 2'd0; bank_set = 1; rfr_ack = 1;
    tick();
    clr_cmds();
    cs = 8'hFF; bank_adr = 2'd0;
    tick();
    check("rfr_bank0", bank_open, 0);
    check("rfr_any", any_bank_open, 0);
    bank_adr = 2'd3;
    tick();
    check("rfr_bank3", bank_open, 0);

    // Idle expiry, hold, ack
    idle_limit = 8'd4;
    open_bank(8'h02, 2'd2, 13'h0001);
    wait_req("idle_req", n);
    check("idle_latency", n, 5);
    check("idle_cs", close_cs, 1);
    check("idle_bank", close_bank, 2);
    hits = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (close_req === 1'b1 && close_cs === 3'd1 && close_bank === 2'd2) hits++;
    end
    check("idle_hold_stable", hits, 3);
    ack_req();
    check("idle_ack_drop", close_req, 0);
    tick();
    check("idle_closed", bank_open, 0);
    check("idle_no_regrant", close_req, 0);

    // Round-robin arbitration
    do_reset();
    idle_limit = 0;
    open_bank(8'h01, 2'd0, 13'h0010);
    open_bank(8'h01, 2'd3, 13'h0011);
    open_bank(8'h08, 2'd1, 13'h0012);
    idle_limit = 8'd4;
    wait_req("rr_req0", n);
    check("rr_g0", {close_cs, close_bank}, {3'd0, 2'd0});
    ack_req();
    wait_req("rr_req1", n);
    check("rr_g1", {close_cs, close_bank}, {3'd0, 2'd3});
    ack_req();
    wait_req("rr_req2", n);
    check("rr_g2", {close_cs, close_bank}, {3'd3, 2'd1});
    ack_req();
    idle_limit = 0;
    open_bank(8'h01, 2'd0, 13'h0020);
    open_bank(8'h01, 2'd3, 13'h0021);
    open_bank(8'h08, 2'd1, 13'h0022);
    open_bank(8'h08, 2'd3, 13'h0023);
    idle_limit = 8'd4;
    wait_req("rr_req3", n);
    check("rr_g3_after13", {close_cs, close_bank}, {3'd3, 2'd3});
    ack_req();
    wait_req("rr_req4", n);
    check("rr_g4_wrap", {close_cs, close_bank}, {3'd0, 2'd0});
    ack_req();
    idle_limit = 0;

    // Withdrawal by precharge and by touch
    do_reset();
    idle_limit = 8'd4;
    open_bank(8'h02, 2'd2, 13'h0033);
    wait_req("wd_req", n);
    bank_clr = 1;
    tick();
    bank_clr = 0;
    check("wd_clr_drop", close_req, 0);
    close_ack = 1;
    tick();
    close_ack = 0;
    check("wd_late_ack", close_req, 0);
    open_bank(8'h02, 2'd2, 13'h0034);
    wait_req("wd_req2", n);
    bank_touch = 1; close_ack = 1;
    tick();
    clr_cmds();
    check("wd_touch_drop", close_req, 0);
    tick();
    check("wd_touch_still_open", bank_open, 1);
    check("wd_touch_no_req", close_req, 0);

    // Timeout disabled, then asynchronous reset mid-request
    do_reset();
    idle_limit = 0;
    open_bank(8'h01, 2'd0, 13'h0040);
    open_bank(8'h80, 2'd2, 13'h0041);
    hits = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (close_req !== 1'b0) hits++;
    end
    check("nolimit_no_req", hits, 0);
    idle_limit = 8'd4;
    wait_req("arst_req", n);
    check("arst_pre_open", bank_open, 1);
    #2;
    rst = 0;
    #1;
    check("arst_close_req", close_req, 0);
    check("arst_close_cs", close_cs, 0);
    check("arst_close_bank", close_bank, 0);
    check("arst_bank_open", bank_open, 0);
    check("arst_row_same", row_same, 0);
    check("arst_any_open", any_bank_open, 0);
    tick();
    rst = 1;
    tick();
    check("arst_entries_clear", bank_open, 0);
    check("arst_no_req", close_req, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
